grf_wb_arbiter: RTL and testbench
=================================

// Module: grf_wb_arbiter
// PURPOSE
//  - Shares the single GRF write port (WE/A3/WD/PC) among NREQ writeback requesters, e.g. the
//    pipeline W stage and the multi-cycle multiply/divide unit.
//  - Keeps a per-register busy scoreboard that the hazard unit reads to stall consumers of
//    registers with a pending write.
//  - Sits between the writeback sources and the GRF; drives the GRF write port directly.
// PARAMETERS
//  NREQ  2   number of writeback requesters (2..4)
//  AW    5   register address width (2**AW registers; register 0 hard-wired zero)
//  DW    32  data and PC width
// PORTS
//  clk        in   1        clock; all state updates on posedge
//  rst_n      in   1        asynchronous, active-low reset
//  req_valid  in   NREQ     requester i holds a write
//  req_ready  out  NREQ     one-hot grant; handshake completes when valid&ready in the same cycle
//  req_addr   in   NREQ*AW  destination register, requester i in slice [i*AW +: AW]
//  req_data   in   NREQ*DW  write data, slice [i*DW +: DW]
//  req_pc     in   NREQ*DW  PC of the producing instruction (for the GRF write trace)
//  rsv_valid  in   1        reserve: an instruction with a destination issued this cycle
//  rsv_addr   in   AW       register to mark busy
//  q_a1       in   AW       scoreboard query address 1
//  q_a2       in   AW       scoreboard query address 2
//  q_busy1    out  1        combinational busy bit of q_a1 (always 0 for register 0)
//  q_busy2    out  1        combinational busy bit of q_a2 (always 0 for register 0)
//  grf_we     out  1        GRF write enable
//  grf_a3     out  AW       GRF write address
//  grf_wd     out  DW       GRF write data
//  grf_pc     out  DW       GRF trace PC
// BEHAVIOUR
//  - Reset (async assert, sync-release use): grf_we=0, grf_a3=0, grf_wd=0, grf_pc=0, all busy
//    bits=0, round-robin pointer=0. Reset mid-transfer discards any granted, unwritten data.
//  - Arbitration:
//    - Round-robin, at most one grant per cycle.
//    - Search starts at pointer p; pointer becomes (granted index + 1) mod NREQ after each grant.
//    - Pointer holds when nothing is granted.
//    - req_ready is combinational from req_valid and p; no grant when no valid.
//    - Requester holds valid, addr, data and pc stable until ready.
//  - Write stage (latency 1):
//    - Grant in cycle t registers addr/data/pc.
//    - grf_we=1 in cycle t+1; GRF commits at the end of t+1.
//    - No grant in t gives grf_we=0 in t+1; grf_a3/wd/pc hold their previous values.
//  - Register 0:
//    - A granted request with addr 0 completes the handshake but gives grf_we=0.
//    - Busy bit 0 is never set.
//  - Scoreboard:
//    - rsv_valid sets busy[rsv_addr] at the edge.
//    - An edge with grf_we=1 clears busy[grf_a3].
//    - Both in one cycle for the same register: set wins, because a newer producer exists.
//    - Reserving an already-busy register keeps it busy; a later write clears it.
//    - The team accepts that WAW ordering is the hazard unit's responsibility.
//    - Queries read the current busy bits with no bypass of the same-cycle clear.
//  - No back-pressure from the GRF: the write stage is always able to accept one grant per cycle.
// STRUCTURE
//  - Shared package/header: AW, DW, REG_ZERO=0, NREG=32.
//  - One sub-module: rr_arbiter (NREQ-wide, valid in, one-hot grant out, pointer register inside).
//  - The top level holds the write-stage registers, the output muxing and the busy[NREG-1:0] vector.
// TESTING
//  1 Reset:
//    - Hold rst_n=0 with req_valid=2'b11 -> grf_we=0, req_ready ignored, q_busy1/2=0.
//    - Release -> first grant goes to requester 0.
//  2 Round-robin:
//    - req_valid=2'b11 held for 4 cycles -> req_ready sequence 01,10,01,10.
//    - grf_a3 follows one cycle later.
//  3 Single write:
//    - Requester 1 writes addr=5, data=0x1234, pc=0x3004 at t.
//    - At t+1: grf_we=1, grf_a3=5, grf_wd=0x1234, grf_pc=0x3004.
//    - At t+2: grf_we=0.
//  4 Zero register:
//    - Requester 0 writes addr=0, data=0xFFFFFFFF -> req_ready=1 and grf_we=0 next cycle.
//    - rsv_addr=0 -> q_busy stays 0.
//  5 Scoreboard:
//    - rsv $8 -> q_a1=8 gives q_busy1=1.
//    - Write $8 -> busy clears after the grf_we=1 edge.
//    - Same-cycle rsv $8 and grf_we to $8 -> stays busy.
//  6 Async reset mid-operation:
//    - With busy[3]=1 and grf_we=1 pending, pulse rst_n low between edges.
//    - Required: outputs go 0 immediately, busy cleared, pointer=0.

Source files
------------

// File: rtl/grf_wb_arbiter_pkg.sv
// Shared constants for the GRF writeback arbiter.
// Register file geometry and the hard-wired zero register.
package grf_wb_arbiter_pkg;
    localparam int AW       = 5;
    localparam int DW       = 32;
    localparam int REG_ZERO = 0;
    localparam int NREG     = 32;
endpackage

// File: rtl/grf_wb_arbiter_if.sv
// Writeback request bundle between the requesters and the arbiter.
// Each requester owns one slice of the packed address/data/pc vectors.
interface grf_wb_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = grf_wb_arbiter_pkg::AW,
    parameter int DW   = grf_wb_arbiter_pkg::DW
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ*DW-1:0] req_pc;

    modport master (
        output req_valid, req_addr, req_data, req_pc,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_pc,
        output req_ready
    );
endinterface

// File: rtl/grf_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the pointer.
// The pointer moves past the winner and holds when nothing is granted.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] grant
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic          found;

    // Distance k from the pointer defines priority; closest valid wins.
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && valid[i] &&
                    ((i + NREQ - int'(ptr)) % NREQ) == k) begin
                    grant[i] = 1'b1;
                    ptr_nxt  = PW'((i + 1) % NREQ);
                    found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end
endmodule

// File: rtl/grf_wb_arbiter.sv
// Shares the GRF write port among writeback requesters and tracks
// per-register pending writes for the hazard unit.
module grf_wb_arbiter
    import grf_wb_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = grf_wb_arbiter_pkg::AW,
    parameter int DW   = grf_wb_arbiter_pkg::DW
) (
    input  logic            clk,
    input  logic            rst_n,
    grf_wb_arbiter_if.slave req,
    input  logic            rsv_valid,
    input  logic [AW-1:0]   rsv_addr,
    input  logic [AW-1:0]   q_a1,
    input  logic [AW-1:0]   q_a2,
    output logic            q_busy1,
    output logic            q_busy2,
    output logic            grf_we,
    output logic [AW-1:0]   grf_a3,
    output logic [DW-1:0]   grf_wd,
    output logic [DW-1:0]   grf_pc
);
    localparam int NR = 1 << AW;

    logic [NREQ-1:0] grant;
    logic            any_grant;
    logic [AW-1:0]   g_addr;
    logic [DW-1:0]   g_data;
    logic [DW-1:0]   g_pc;
    logic [NR-1:0]   busy;
    logic [NR-1:0]   busy_nxt;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (req.req_valid),
        .grant (grant)
    );

    assign req.req_ready = grant;
    assign any_grant     = |grant;

    always_comb begin
        g_addr = '0;
        g_data = '0;
        g_pc   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                g_addr = req.req_addr[i*AW +: AW];
                g_data = req.req_data[i*DW +: DW];
                g_pc   = req.req_pc[i*DW +: DW];
            end
        end
    end

    // Set after clear: a same-cycle reserve means a newer producer exists.
    always_comb begin
        busy_nxt = busy;
        if (grf_we) begin
            busy_nxt[grf_a3] = 1'b0;
        end
        if (rsv_valid) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
        busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grf_we <= 1'b0;
            grf_a3 <= '0;
            grf_wd <= '0;
            grf_pc <= '0;
            busy   <= '0;
        end else begin
            grf_we <= any_grant && (g_addr != AW'(REG_ZERO));
            if (any_grant) begin
                grf_a3 <= g_addr;
                grf_wd <= g_data;
                grf_pc <= g_pc;
            end
            busy <= busy_nxt;
        end
    end

    assign q_busy1 = busy[q_a1];
    assign q_busy2 = busy[q_a2];
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter with two requesters.
// Inputs change 1ns after posedge; outputs are sampled there too.
module tb_grf_wb_arbiter;
    logic        clk;
    logic        rst_n;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic [4:0]  q_a1;
    logic [4:0]  q_a2;
    logic        q_busy1;
    logic        q_busy2;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;

    int errors = 0;
    int checks = 0;

    grf_wb_arbiter_if #(.NREQ(2), .AW(5), .DW(32)) bus ();

    grf_wb_arbiter #(.NREQ(2), .AW(5), .DW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.slave),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .q_a1      (q_a1),
        .q_a2      (q_a2),
        .q_busy1   (q_busy1),
        .q_busy2   (q_busy2),
        .grf_we    (grf_we),
        .grf_a3    (grf_a3),
        .grf_wd    (grf_wd),
        .grf_pc    (grf_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_addr  = {5'd2, 5'd1};
        bus.req_data  = {32'h0000_000B, 32'h0000_000A};
        bus.req_pc    = {32'h0000_2004, 32'h0000_1000};
        rsv_valid     = 1'b0;
        rsv_addr      = 5'd0;
        q_a1          = 5'd8;
        q_a2          = 5'd3;

        // Reset held with both requesters valid
        #3;
        chk("rst_we", 64'(grf_we), 64'd0);
        chk("rst_a3", 64'(grf_a3), 64'd0);
        chk("rst_busy1", 64'(q_busy1), 64'd0);
        chk("rst_busy2", 64'(q_busy2), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("first_ready", 64'(bus.req_ready), 64'b01);

        // Round-robin alternation, write address lags one cycle
        tick();
        chk("rr1_we", 64'(grf_we), 64'd1);
        chk("rr1_a3", 64'(grf_a3), 64'd1);
        chk("rr1_ready", 64'(bus.req_ready), 64'b10);
        tick();
        chk("rr2_a3", 64'(grf_a3), 64'd2);
        chk("rr2_wd", 64'(grf_wd), 64'h0B);
        chk("rr2_ready", 64'(bus.req_ready), 64'b01);
        tick();
        chk("rr3_a3", 64'(grf_a3), 64'd1);
        chk("rr3_ready", 64'(bus.req_ready), 64'b10);
        tick();
        chk("rr4_a3", 64'(grf_a3), 64'd2);
        chk("rr4_ready", 64'(bus.req_ready), 64'b01);
        bus.req_valid = 2'b00;
        tick();
        chk("idle_we", 64'(grf_we), 64'd0);
        chk("idle_a3_hold", 64'(grf_a3), 64'd2);

        // Single write from requester 1
        bus.req_valid = 2'b10;
        bus.req_addr  = {5'd5, 5'd0};
        bus.req_data  = {32'h0000_1234, 32'h0};
        bus.req_pc    = {32'h0000_3004, 32'h0};
        #1;
        chk("sw_ready", 64'(bus.req_ready), 64'b10);
        tick();
        bus.req_valid = 2'b00;
        chk("sw_we", 64'(grf_we), 64'd1);
        chk("sw_a3", 64'(grf_a3), 64'd5);
        chk("sw_wd", 64'(grf_wd), 64'h1234);
        chk("sw_pc", 64'(grf_pc), 64'h3004);
        tick();
        chk("sw_we_drop", 64'(grf_we), 64'd0);

        // Register 0: handshake completes, no write, never busy
        bus.req_valid = 2'b01;
        bus.req_addr  = {5'd0, 5'd0};
        bus.req_data  = {32'h0, 32'hFFFF_FFFF};
        rsv_valid     = 1'b1;
        rsv_addr      = 5'd0;
        q_a1          = 5'd0;
        #1;
        chk("z_ready", 64'(bus.req_ready), 64'b01);
        tick();
        bus.req_valid = 2'b00;
        rsv_valid     = 1'b0;
        chk("z_we", 64'(grf_we), 64'd0);
        chk("z_busy", 64'(q_busy1), 64'd0);

        // Scoreboard reserve, then clear by write
        q_a1      = 5'd8;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd8;
        #1;
        chk("sb_pre", 64'(q_busy1), 64'd0);
        tick();
        rsv_valid = 1'b0;
        chk("sb_set", 64'(q_busy1), 64'd1);
        bus.req_valid = 2'b01;
        bus.req_addr  = {5'd0, 5'd8};
        bus.req_data  = {32'h0, 32'h88};
        tick();
        bus.req_valid = 2'b00;
        chk("sb_w_we", 64'(grf_we), 64'd1);
        chk("sb_w_a3", 64'(grf_a3), 64'd8);
        chk("sb_nobypass", 64'(q_busy1), 64'd1);
        tick();
        chk("sb_clear", 64'(q_busy1), 64'd0);

        // Same-edge reserve and write of $8: stays busy
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        chk("sb2_we", 64'(grf_we), 64'd1);
        rsv_valid = 1'b1;
        rsv_addr  = 5'd8;
        tick();
        rsv_valid = 1'b0;
        chk("sb2_busy", 64'(q_busy1), 64'd1);
        chk("sb2_we_drop", 64'(grf_we), 64'd0);

        // Async reset with busy[3] set and a write pending
        bus.req_valid = 2'b01;
        bus.req_addr  = {5'd0, 5'd9};
        bus.req_data  = {32'h0, 32'h99};
        bus.req_pc    = {32'h0, 32'h4000};
        rsv_valid     = 1'b1;
        rsv_addr      = 5'd3;
        tick();
        bus.req_valid = 2'b00;
        rsv_valid     = 1'b0;
        chk("ar_we_pre", 64'(grf_we), 64'd1);
        chk("ar_busy3", 64'(q_busy2), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_we", 64'(grf_we), 64'd0);
        chk("ar_a3", 64'(grf_a3), 64'd0);
        chk("ar_wd", 64'(grf_wd), 64'd0);
        chk("ar_pc", 64'(grf_pc), 64'd0);
        chk("ar_busy8", 64'(q_busy1), 64'd0);
        chk("ar_busy3_clr", 64'(q_busy2), 64'd0);
        bus.req_valid = 2'b11;
        bus.req_addr  = {5'd6, 5'd4};
        rst_n         = 1'b1;
        #1;
        chk("ar_ptr0", 64'(bus.req_ready), 64'b01);
        tick();
        chk("ar_post_we", 64'(grf_we), 64'd1);
        chk("ar_post_a3", 64'(grf_a3), 64'd4);
        bus.req_valid = 2'b00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
